// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide)
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    res_q, res_d;

  logic            signed_a, signed_b, sign_a, sign_b;
  logic            is_div, is_rem, div_zero, div_ovf, div_ok;
  logic [W-1:0]    a_abs, b_abs, quot_fix, rem_fix, fix_word;
  logic [W:0]      mul_sum, rem_sh, div_diff;
  logic [2*W-1:0]  prod_fix;

  assign signed_a = (op_q == 3'b001) | (op_q == 3'b010) | (op_q == 3'b100) | (op_q == 3'b110);
  assign signed_b = (op_q == 3'b001) | (op_q == 3'b100) | (op_q == 3'b110);
  assign sign_a   = signed_a & a_q[W-1];
  assign sign_b   = signed_b & b_q[W-1];
  assign a_abs    = sign_a ? -a_q : a_q;
  assign b_abs    = sign_b ? -b_q : b_q;
  assign is_div   = op_q[2];
  assign is_rem   = op_q[2] & op_q[1];
  assign div_zero = is_div & (b_q == '0);
  assign div_ovf  = is_div & ~op_q[0] & (a_q == MIN_NEG) & (b_q == {W{1'b1}});

  // prod_q doubles as {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign rem_sh   = prod_q[2*W-1:W-1];
  assign div_diff = rem_sh - {1'b0, b_q};
  assign div_ok   = ~div_diff[W];

  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign quot_fix = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
  assign rem_fix  = neg_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];

  always_comb begin
    fix_word = '0;
    case (op_q)
      3'b000:                 fix_word = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_word = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_word = quot_fix;
      default:                fix_word = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = PREP;
          op_d    = op;
          a_d     = SrcA;
          b_d     = SrcB;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      PREP: begin
        a_d   = a_abs;
        b_d   = b_abs;
        cnt_d = CW'(W);
        if (div_zero) begin
          prod_d  = {a_q, {W{1'b1}}};
          neg_d   = 1'b0;
          state_d = FIX;
        end else if (div_ovf) begin
          prod_d  = {{W{1'b0}}, MIN_NEG};
          neg_d   = 1'b0;
          state_d = FIX;
        end else begin
          prod_d  = is_div ? {{W{1'b0}}, a_abs} : {{W{1'b0}}, b_abs};
          neg_d   = is_rem ? sign_a : (sign_a ^ sign_b);
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div)
          prod_d = {(div_ok ? div_diff[W-1:0] : rem_sh[W-1:0]), prod_q[W-2:0], div_ok};
        else
          prod_d = {mul_sum, prod_q[W-1:1]};
        if (cnt_q == CW'(1))
          state_d = FIX;
      end
      FIX: begin
        res_d   = fix_word;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .flush(flush), .busy(busy), .done(done), .Result(Result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // start sampled at the posedge closing cycle 0; returns in cycle 1 just after that edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; op = 3'($urandom);
  endtask

  task automatic wait_done(output int lat, output logic busy_ok);
    logic found;
    found = 1'b0; lat = -1; busy_ok = 1'b1;
    for (int c = 1; c <= 60 && !found; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        found = 1'b1;
      end
    end
  endtask

  task automatic no_done(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic bok;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35};
    vecs[4]  = '{3'b011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 35};
    vecs[5]  = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 35};
    vecs[6]  = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35};
    vecs[7]  = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 35};
    vecs[8]  = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 35};
    vecs[9]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 35};
    vecs[10] = '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 3};
    vecs[11] = '{3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 3};
    vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3};
    vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3};
    vecs[14] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 3};
    vecs[15] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 35};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_held", i), {31'd0, bok}, 32'd1);
      chk($sformatf("vec%0d_result", i), Result, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // back-to-back DIV then REM, second start in the DONE cycle
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat, bok);
    chk("b2b_div_latency", 32'(lat), 32'd35);
    chk("b2b_div_result", Result, 32'hFFFF_FFFD);
    op = 3'b110; SrcA = 32'hFFFF_FFF9; SrcB = 32'h0000_0002; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    wait_done(lat, bok);
    chk("b2b_rem_latency", 32'(lat), 32'd35);
    chk("b2b_rem_busy_held", {31'd0, bok}, 32'd1);
    chk("b2b_rem_result", Result, 32'hFFFF_FFFF);

    // flush in cycle 10 of a DIVU
    issue(3'b101, 32'h0000_0064, 32'h0000_0007);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_c11", {31'd0, busy}, 32'd0);
    no_done("flush_no_done", 40);
    chk("flush_result_kept", Result, 32'hFFFF_FFFF);

    // start and flush together in IDLE
    @(negedge clk);
    op = 3'b000; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_busy", {31'd0, busy}, 32'd0);
    no_done("start_flush_no_done", 40);

    // start while busy is ignored
    issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    op = 3'b101; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    chk("ignored_start_latency", 32'(lat), 32'd30);
    chk("ignored_start_result", Result, 32'hFFFF_FFEB);
    no_done("ignored_start_single_done", 40);

    // asynchronous reset in cycle 20 of a MUL
    issue(3'b000, 32'h0000_0003, 32'h0000_0005);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_done", {31'd0, done}, 32'd0);
    chk("async_reset_result", Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("async_reset_no_done", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle sequencer for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the execute stage and receives the same `SrcA`/`SrcB` operands. It runs a shift-add multiply or restoring divide over DATA_WIDTH cycles and holds `busy` high so the hazard unit stalls the pipeline until `done`. The result is muxed into the ALUResult path when `done` is high.

## Interface
- DATA_WIDTH, 32, operand/result width; must be even and ≥ 4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when state is IDLE or DONE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  DATA_WIDTH  multiplicand / dividend
- SrcB  in  DATA_WIDTH  multiplier / divisor
- flush  in  1  synchronous abort (branch mispredict / trap)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; Result valid
- Result  out  DATA_WIDTH  registered result, held until the next accepted start completes

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE/DONE + start (no flush):
  - latch op, SrcA, SrcB; go to PREP.
  - DONE without start goes to IDLE.
- PREP:
  - Compute absolute values of the operands that are signed for this op (MULH: both; MULHSU: A only; DIV/REM: both).
  - Record result sign. Product and quotient sign = signA XOR signB; remainder sign = signA.
  - Clear the accumulator and load counter = DATA_WIDTH.
  - Special cases skip CALC and go to FIX with a preset result:
    - Divide-by-zero: quotient = all ones, remainder = dividend (unsigned, unnegated).
    - Signed overflow (DIV/REM with A = 0x80000000, B = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Otherwise go to CALC.
- CALC: one iteration per cycle; decrement counter; at counter = 1 go to FIX.
  - Multiply: 2·DATA_WIDTH product register, shift-add on the LSB of the multiplier.
  - Divide: restoring. Shift the remainder left and bring in the next dividend bit. Trial-subtract the divisor; if non-negative, keep it and set the quotient bit.
- FIX:
  - Apply the sign by two's-complement negation of the full 2·DATA_WIDTH product, or of the quotient/remainder.
  - Select the output word: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - Write Result and go to DONE.
- DONE: done = 1 for one cycle.
- flush: any state → IDLE next cycle. No done pulse, Result unchanged. Flush overrides start in the same cycle.
- start while in PREP/CALC/FIX is ignored; no queuing.

## Timing
- Reset values: state IDLE, busy 0, done 0, Result 0, internal registers 0.
- Reset takes effect asynchronously mid-operation; no done follows.
- Normal latency, with start sampled in cycle 0:
  - PREP cycle 1, CALC cycles 2..DATA_WIDTH+1, FIX cycle DATA_WIDTH+2.
  - done in cycle DATA_WIDTH+3 (35 at default width).
- Special-case latency: PREP cycle 1, FIX cycle 2, done in cycle 3.
- busy is 1 from cycle 1 through the DONE cycle inclusive.
- busy is 0 in the start cycle itself; the pipeline uses `start | busy` to stall.
- Back-to-back: start in the DONE cycle is accepted, with the next PREP in the following cycle. busy stays high across the boundary.
- Operands are latched at start; later changes to SrcA/SrcB/op have no effect.
- All arithmetic is modulo 2^DATA_WIDTH except the internal 2·DATA_WIDTH product. No X propagation on unused bits.

## Test plan
- MUL 7 × 0xFFFFFFFD: done in cycle 35, Result = 0xFFFFFFEB. busy is high in cycles 1–35 and low in cycle 36.
- Multiply high words:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide, then back-to-back:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF, issued with start in the DONE cycle; second done 35 cycles after that start.
- Special cases, each with done in cycle 3:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF.
  - REM 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Abort paths:
  - flush asserted in cycle 10 of a DIVU: busy drops in cycle 11, no done, Result keeps its prior value.
  - start and flush together in IDLE: no operation begins.
- Reset and ignored start:
  - rst_n pulsed low in cycle 20 of a MUL: busy, done and Result go to 0 immediately.
  - start while busy is ignored: a single done follows, carrying the first operation's result.
